// File: rtl/perf_event_monitor.sv
// Performance-counter unit: a cycle counter plus NUM_EVT saturating event
// counters over a programmable window, with a snapshot shadow bank and a registered read port.
module perf_event_monitor #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int IDX_W   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 clr_i,
  input  logic [NUM_EVT-1:0]   evt_i,
  input  logic [CNT_W-1:0]     cyc_limit_i,
  input  logic                 snap_i,
  input  logic                 rd_req_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic                 rd_valid_o,
  output logic [CNT_W-1:0]     rd_data_o,
  output logic [NUM_EVT:0]     ovf_o,
  output logic                 running_o,
  output logic                 done_o
);

  localparam int NC = NUM_EVT + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q   [NC];
  logic [CNT_W-1:0] cnt_inc [NC];
  logic [CNT_W-1:0] shd_q   [NC];
  logic [NC-1:0]    ovf_q, ovf_inc, shd_ovf_q, inc_en;
  logic [CNT_W-1:0] rd_sel;
  logic             rd_valid_q, running_q, done_q;
  logic [CNT_W-1:0] rd_data_q;

  // Slot 0 is the cycle counter; slot k+1 follows evt_i[k].
  always_comb begin
    inc_en    = '0;
    inc_en[0] = (state_q == S_RUN);
    for (int k = 0; k < NUM_EVT; k++) begin
      inc_en[k+1] = (state_q == S_RUN) & evt_i[k];
    end
  end

  // Saturating increment: an all-ones counter holds and flags overflow.
  always_comb begin
    for (int k = 0; k < NC; k++) begin
      cnt_inc[k] = cnt_q[k];
      ovf_inc[k] = ovf_q[k];
      if (inc_en[k]) begin
        if (&cnt_q[k]) begin
          ovf_inc[k] = 1'b1;
        end else begin
          cnt_inc[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if ((cyc_limit_i != '0) && (cnt_inc[0] == cyc_limit_i)) state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (clr_i) state_d = S_IDLE;
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NC; k++) begin
      if (rd_idx_i == IDX_W'(k)) rd_sel = shd_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      ovf_q      <= '0;
      shd_ovf_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < NC; k++) begin
        cnt_q[k] <= '0;
        shd_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      if (clr_i) begin
        ovf_q <= '0;
        for (int k = 0; k < NC; k++) cnt_q[k] <= '0;
      end else begin
        ovf_q <= ovf_inc;
        for (int k = 0; k < NC; k++) cnt_q[k] <= cnt_inc[k];
      end
      // The shadow captures the incremented, pre-clear values.
      if (snap_i) begin
        shd_ovf_q <= ovf_inc;
        for (int k = 0; k < NC; k++) shd_q[k] <= cnt_inc[k];
      end
      rd_valid_q <= rd_req_i;
      if (rd_req_i) rd_data_q <= rd_sel;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign ovf_o      = shd_ovf_q;
  assign running_o  = running_q;
  assign done_o     = done_q;

endmodule
